// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin mining blocks.
//   NUM_NONCES_DEFAULT : default number of result words scanned
//   MEM_RD_LATENCY     : cycles from address sampled by memory to data valid
//   HASH_MAX           : largest hash word, used as the "no minimum yet" seed
//   scan_state_t       : result-scanner FSM states
//   nonce_width()      : nonce index width, never below one bit
package bitcoin_pkg;

  localparam int          NUM_NONCES_DEFAULT = 16;
  localparam int          MEM_RD_LATENCY     = 1;
  localparam int          HASH_W             = 32;
  localparam int          ADDR_W             = 16;
  localparam logic [31:0] HASH_MAX           = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_ISSUE,
    SCAN_DRAIN,
    SCAN_DONE
  } scan_state_t;

  function automatic int nonce_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_min_tracker.sv
// Registered reducer over a stream of (index, hash) words.
// Tracks the minimum hash and its index (ties keep the earliest index), and
// counts words below a threshold, remembering the first such index.
//   clk, reset     : clock, synchronous active-high reset
//   clear          : reseed all results before a new stream
//   vld_p0         : idx_p0/data_p0 carry a word this cycle
//   idx_p0         : nonce index of the word
//   data_p0        : hash word
//   target         : unsigned threshold, must be stable while streaming
//   found          : at least one word below target
//   first_nonce    : earliest index below target
//   best_nonce     : index of the minimum word
//   best_hash      : minimum word
//   hit_count      : number of words below target
module nonce_min_tracker
  import bitcoin_pkg::*;
#(
  parameter int DATA_W = HASH_W,
  parameter int NW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              vld_p0,
  input  logic [NW-1:0]     idx_p0,
  input  logic [DATA_W-1:0] data_p0,
  input  logic [DATA_W-1:0] target,
  output logic              found,
  output logic [NW-1:0]     first_nonce,
  output logic [NW-1:0]     best_nonce,
  output logic [DATA_W-1:0] best_hash,
  output logic [NW:0]       hit_count
);

  logic below_best;
  logic below_target;

  // Strict compares: an equal hash never displaces an earlier minimum,
  // so ties resolve to the lower nonce for free.
  assign below_best   = (data_p0 < best_hash);
  assign below_target = (data_p0 < target);

  // stage p0 -> results
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      found       <= 1'b0;
      first_nonce <= '0;
      best_nonce  <= '0;
      best_hash   <= '1;
      hit_count   <= '0;
    end else if (vld_p0) begin
      if (below_best) begin
        best_hash  <= data_p0;
        best_nonce <= idx_p0;
      end
      if (below_target) begin
        hit_count <= hit_count + {{NW{1'b0}}, 1'b1};
        if (!found) begin
          found       <= 1'b1;
          first_nonce <= idx_p0;
        end
      end
    end
  end

endmodule

// File: rtl/bitcoin_result_scanner.sv
// Scans NUM_NONCES consecutive hash words from the shared synchronous memory
// and reports the minimum hash, its nonce, the first nonce below target and
// the number of hits. One address is issued per cycle with no bubbles.
//   clk, reset      : clock, synchronous active-high reset
//   start           : begin a scan (only honoured in IDLE)
//   output_addr     : address of the word for nonce 0, taken with start
//   target          : unsigned threshold, taken with start
//   done            : one-cycle pulse when results are final
//   found, first_nonce, best_nonce, best_hash, hit_count : scan results
//   mem_clk, mem_we, mem_addr, mem_write_data, mem_read_data : memory port
//     (read-only use; data valid the cycle after memory samples mem_addr)
module bitcoin_result_scanner
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEFAULT,
  parameter int NW         = nonce_width(NUM_NONCES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [HASH_W-1:0] target,
  output logic              done,
  output logic              found,
  output logic [NW-1:0]     first_nonce,
  output logic [NW-1:0]     best_nonce,
  output logic [HASH_W-1:0] best_hash,
  output logic [NW:0]       hit_count,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [HASH_W-1:0] mem_write_data,
  input  logic [HASH_W-1:0] mem_read_data
);

  localparam logic [NW:0]   N_CNT    = (NW+1)'(NUM_NONCES);
  localparam logic [NW-1:0] LAST_IDX = NW'(NUM_NONCES - 1);

  scan_state_t state, state_nxt;

  logic              accept;
  logic              issue_end;
  logic              last_cmp;
  logic [NW:0]       issue_cnt;
  logic [HASH_W-1:0] target_q;

  logic              addr_vld;
  logic [NW-1:0]     addr_idx;
  logic              vld_m1;
  logic [NW-1:0]     idx_m1;
  logic              vld_p0;
  logic [NW-1:0]     idx_p0;
  logic [HASH_W-1:0] data_p0;

  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_write_data = '0;

  assign accept    = (state == SCAN_IDLE) && start;
  assign issue_end = (issue_cnt == N_CNT);
  assign last_cmp  = vld_p0 && (idx_p0 == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN_IDLE:  if (start)     state_nxt = SCAN_ISSUE;
      SCAN_ISSUE: if (issue_end) state_nxt = SCAN_DRAIN;
      SCAN_DRAIN: if (last_cmp)  state_nxt = SCAN_DONE;
      SCAN_DONE:                 state_nxt = SCAN_IDLE;
      default:                   state_nxt = SCAN_IDLE;
    endcase
  end

  // Control: FSM, address issue and valid pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN_IDLE;
      done      <= 1'b0;
      mem_addr  <= '0;
      issue_cnt <= '0;
      addr_vld  <= 1'b0;
      vld_m1    <= 1'b0;
      vld_p0    <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Registered so the pulse lands one cycle after the last compare has
      // settled into the result registers.
      done   <= (state == SCAN_DONE);
      vld_m1 <= addr_vld;
      vld_p0 <= vld_m1;
      case (state)
        SCAN_IDLE: begin
          addr_vld <= start;
          if (start) begin
            mem_addr  <= output_addr;
            issue_cnt <= (NW+1)'(1);
          end
        end
        SCAN_ISSUE: begin
          if (issue_end) begin
            addr_vld <= 1'b0;
          end else begin
            // 16-bit wrap is intended: a scan may straddle the top of memory.
            mem_addr  <= mem_addr + 16'd1;
            issue_cnt <= issue_cnt + (NW+1)'(1);
            addr_vld  <= 1'b1;
          end
        end
        default: addr_vld <= 1'b0;
      endcase
    end
  end

  // Data: operand latch and index tracking (no reset needed, qualified by vld).
  always_ff @(posedge clk) begin
    if (accept) begin
      target_q <= target;
      addr_idx <= '0;
    end else if ((state == SCAN_ISSUE) && !issue_end) begin
      addr_idx <= issue_cnt[NW-1:0];
    end
    // stage m1: memory samples mem_addr at this edge
    idx_m1  <= addr_idx;
    // stage p0: read word captured alongside its nonce index
    idx_p0  <= idx_m1;
    data_p0 <= mem_read_data;
  end

  nonce_min_tracker #(
    .DATA_W (HASH_W),
    .NW     (NW)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .clear       (accept),
    .vld_p0      (vld_p0),
    .idx_p0      (idx_p0),
    .data_p0     (data_p0),
    .target      (target_q),
    .found       (found),
    .first_nonce (first_nonce),
    .best_nonce  (best_nonce),
    .best_hash   (best_hash),
    .hit_count   (hit_count)
  );

endmodule

// File: tb/tb_bitcoin_result_scanner.sv
module tb_bitcoin_result_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  // 16-nonce instance
  logic        start16;
  logic [15:0] base16;
  logic [31:0] target16;
  logic        done16, found16;
  logic [3:0]  first16, best16;
  logic [31:0] hash16;
  logic [4:0]  hit16;
  logic        mclk16, we16;
  logic [15:0] addr16;
  logic [31:0] wdata16, rdata16;

  // 1-nonce instance
  logic        start1;
  logic [15:0] base1;
  logic [31:0] target1;
  logic        done1, found1;
  logic [0:0]  first1, best1;
  logic [31:0] hash1;
  logic [1:0]  hit1;
  logic        mclk1, we1;
  logic [15:0] addr1;
  logic [31:0] wdata1, rdata1;

  logic [31:0] mem [0:65535];

  int tests = 0;
  int fails = 0;

  bitcoin_result_scanner #(.NUM_NONCES(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .output_addr(base16),
    .target(target16), .done(done16), .found(found16),
    .first_nonce(first16), .best_nonce(best16), .best_hash(hash16),
    .hit_count(hit16), .mem_clk(mclk16), .mem_we(we16), .mem_addr(addr16),
    .mem_write_data(wdata16), .mem_read_data(rdata16)
  );

  bitcoin_result_scanner #(.NUM_NONCES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .output_addr(base1),
    .target(target1), .done(done1), .found(found1),
    .first_nonce(first1), .best_nonce(best1), .best_hash(hash1),
    .hit_count(hit1), .mem_clk(mclk1), .mem_we(we1), .mem_addr(addr1),
    .mem_write_data(wdata1), .mem_read_data(rdata1)
  );

  // One-cycle synchronous read memory shared by both instances.
  always @(posedge clk) begin
    rdata16 <= mem[addr16];
    rdata1  <= mem[addr1];
  end

  // Counts FFFF -> 0000 steps of the 16-nonce read address.
  int          wrap_cnt  = 0;
  logic [15:0] last_addr = 16'h0000;
  always @(negedge clk) begin
    if (last_addr == 16'hFFFF && addr16 == 16'h0000) wrap_cnt <= wrap_cnt + 1;
    last_addr <= addr16;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic f, input logic [3:0] fn,
                         input logic [3:0] bn, input logic [31:0] bh, input logic [4:0] hc);
    check({tag, "_found"}, 32'(found16), 32'(f));
    check({tag, "_first"}, 32'(first16), 32'(fn));
    check({tag, "_best_nonce"}, 32'(best16), 32'(bn));
    check({tag, "_best_hash"}, hash16, bh);
    check({tag, "_hits"}, 32'(hit16), 32'(hc));
  endtask

  // Start a scan on the 16-nonce instance and count edges until done.
  task automatic scan16(input logic [15:0] b, input logic [31:0] t, output int cyc);
    @(negedge clk);
    base16 = b; target16 = t; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done16 && cyc < 60);
  endtask

  initial begin
    int cyc, w0, dcnt, wecnt, first_done, d1, d2;
    logic [15:0] a;

    reset = 1'b1;
    start16 = 1'b0; base16 = '0; target16 = '0;
    start1  = 1'b0; base1  = '0; target1  = '0;

    for (int i = 0; i < 16; i++) begin
      mem[16'h0080 + 16'(i)] = 32'h5000_0000 - 32'(i) * 32'h0100_0000;
      mem[16'h0200 + 16'(i)] = 32'h1234_5678;
      a = 16'hFFF8 + 16'(i);
      mem[a] = 32'h9000_0000 + 32'(i);
      mem[16'h0300 + 16'(i)] = 32'h0000_0010;
      mem[16'h0400 + 16'(i)] = 32'h2000_0000 + 32'(i);
    end
    mem[16'h0003] = 32'h0000_0001;
    mem[16'h0405] = 32'h0000_0100;
    mem[16'h0500] = 32'h0000_0000;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done16), 32'd0);
    check16("rst", 1'b0, 4'd0, 4'd0, 32'hFFFF_FFFF, 5'd0);
    check("rst_mem_addr", 32'(addr16), 32'h0);
    check("rst_mem_we", 32'(we16), 32'd0);
    check("rst_mem_wdata", wdata16, 32'h0);
    check("rst1_best_hash", hash1, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b0;

    // Descending hashes, target 0x48000000
    scan16(16'h0080, 32'h4800_0000, cyc);
    check("t1_latency", 32'(cyc), 32'd19);
    check16("t1", 1'b1, 4'd9, 4'd15, 32'h4100_0000, 5'd7);
    @(posedge clk); #1;
    check("t1_done_pulse", 32'(done16), 32'd0);

    // All equal to target: nothing strictly below
    scan16(16'h0200, 32'h1234_5678, cyc);
    check("t2_latency", 32'(cyc), 32'd19);
    check16("t2", 1'b0, 4'd0, 4'd0, 32'h1234_5678, 5'd0);

    // Address wrap, unique minimum at 0x0003 (nonce 11)
    w0 = wrap_cnt;
    scan16(16'hFFF8, 32'h0000_0002, cyc);
    check("t3_latency", 32'(cyc), 32'd19);
    check16("t3", 1'b1, 4'd11, 4'd11, 32'h0000_0001, 5'd1);
    check("t3_wrap", 32'(wrap_cnt - w0), 32'd1);

    // Reset part-way through a scan, then a fresh scan
    @(negedge clk);
    base16 = 16'h0300; target16 = 32'h0000_0100; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t4_rst_done", 32'(done16), 32'd0);
    check16("t4_rst", 1'b0, 4'd0, 4'd0, 32'hFFFF_FFFF, 5'd0);
    check("t4_rst_mem_addr", 32'(addr16), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done16) dcnt++;
    end
    check("t4_no_done", 32'(dcnt), 32'd0);
    scan16(16'h0400, 32'h0000_0200, cyc);
    check("t4_latency", 32'(cyc), 32'd19);
    check16("t4", 1'b1, 4'd5, 4'd5, 32'h0000_0100, 5'd1);

    // start toggled during a scan must be ignored
    @(negedge clk);
    base16 = 16'h0080; target16 = 32'h4C00_0000; start16 = 1'b1;
    @(posedge clk); #1;
    dcnt = 0; wecnt = 0; first_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c <= 15) begin
        start16  = c[0];
        base16   = 16'h0200;
        target16 = 32'h0;
      end else begin
        start16 = 1'b0;
      end
      @(posedge clk); #1;
      if (done16) begin
        dcnt++;
        if (first_done == 0) first_done = c;
      end
      if (we16 !== 1'b0 || wdata16 !== 32'h0) wecnt++;
    end
    check("t5_done_count", 32'(dcnt), 32'd1);
    check("t5_latency", 32'(first_done), 32'd19);
    check("t5_mem_we", 32'(wecnt), 32'd0);
    check16("t5", 1'b1, 4'd5, 4'd15, 32'h4100_0000, 5'd11);

    // start held high: back-to-back scans, 20 cycles apart
    @(negedge clk);
    base16 = 16'h0080; target16 = 32'h4800_0000; start16 = 1'b1;
    cyc = 0; d1 = 0; d2 = 0;
    while (cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      if (done16) begin
        if (d1 == 0) d1 = cyc;
        else begin
          d2 = cyc;
          break;
        end
      end
    end
    start16 = 1'b0;
    check("t6_first_done", 32'(d1), 32'd20);
    check("t6_restart_period", 32'(d2 - d1), 32'd20);
    check16("t6", 1'b1, 4'd9, 4'd15, 32'h4100_0000, 5'd7);

    // Single-nonce instance
    @(negedge clk);
    base1 = 16'h0500; target1 = 32'h1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done1 && cyc < 60);
    check("t7_latency", 32'(cyc), 32'd4);
    check("t7_found", 32'(found1), 32'd1);
    check("t7_hits", 32'(hit1), 32'd1);
    check("t7_first", 32'(first1), 32'd0);
    check("t7_best_nonce", 32'(best1), 32'd0);
    check("t7_best_hash", hash1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
